// File: rtl/output_scan_reader_if.sv
// Output stream bundle for output_scan_reader.
//   out_data  : streamed word
//   out_valid : out_data holds a word
//   out_ready : the sink takes the word on a cycle where out_valid & out_ready
// master = word producer (the reader), slave = display/serializer sink.
interface output_scan_reader_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/output_scan_reader.sv
// output_scan_reader
// Reads a run of words from the output-controller frame RAM (1-cycle
// registered read) and streams them out on a valid/ready interface.
// A 2-entry skid FIFO hides the RAM latency and absorbs backpressure.
// With the sink always ready it moves one word per cycle.
// Ports:
//   clk, n_rst   : clock, asynchronous active-low reset
//   start        : one-cycle pulse; accepted only while idle
//   start_addr   : first RAM address, latched on accepted start
//   word_count   : number of words (0..2^ADDR_W), latched on accepted start
//   read_address : registered RAM read address
//   ram_q        : RAM read data for the previous cycle's read_address
//   busy         : high from the cycle after an accepted start until done
//   done         : one-cycle pulse after the last word is transferred
//   out_if       : output stream (master side)
module output_scan_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output_scan_reader_if.master out_if
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic [ADDR_W:0]   issue_left_q, issue_left_d;   // reads still to issue
  logic              pending_q, pending_d;         // read issued last cycle
  logic [1:0]        count_q, count_d;             // FIFO occupancy
  logic [DATA_W-1:0] ent0_q, ent0_d;               // FIFO head
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              pop;
  logic              issue;
  logic [2:0]        occ;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    read_address_d = read_address_q;
    issue_left_d   = issue_left_q;
    count_d        = count_q;
    ent0_d         = ent0_q;
    ent1_d         = ent1_q;
    busy_d         = busy_q;
    done_d         = 1'b0;

    pop = (count_q != 2'd0) && out_if.out_ready;

    // Credit: words already in the FIFO plus the one in flight from the RAM.
    // Issuing only while that total (after this cycle's pop) is at most one
    // guarantees a free slot when the new word arrives two cycles later.
    occ   = {1'b0, count_q} + {2'b00, pending_q};
    issue = (state_q == S_READ) && (issue_left_q != '0) &&
            ((occ <= 3'd1) || ((occ == 3'd2) && pop));
    pending_d = issue;

    // FIFO: shift on pop, then write the arriving word behind what remains.
    count_d = count_q + {1'b0, pending_q} - {1'b0, pop};
    if (pop) ent0_d = ent1_q;
    if (pending_q) begin
      if ((count_q - {1'b0, pop}) == 2'd0) ent0_d = ram_q;
      else                                ent1_d = ram_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          read_address_d = start_addr;
          issue_left_d   = word_count;
          if (word_count == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            busy_d  = 1'b1;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          issue_left_d = issue_left_q - (ADDR_W+1)'(1);
          // The last issued address is held rather than advanced.
          if (issue_left_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
          else read_address_d = read_address_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (!pending_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      read_address_q <= '0;
      issue_left_q   <= '0;
      pending_q      <= 1'b0;
      count_q        <= 2'd0;
      // NOTE: the FIFO data registers are reset as well because the head
      // entry is out_data, which must read zero straight out of reset.
      ent0_q         <= '0;
      ent1_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_address_q <= read_address_d;
      issue_left_q   <= issue_left_d;
      pending_q      <= pending_d;
      count_q        <= count_d;
      ent0_q         <= ent0_d;
      ent1_q         <= ent1_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign read_address     = read_address_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_data  = ent0_q;
  assign out_if.out_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_output_scan_reader.sv
// Self-checking bench for output_scan_reader: a frame RAM model, a random or
// always-ready sink, and a scoreboard of expected words built from the RAM
// contents and the requested address run.
module tb_output_scan_reader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] ram_q;
  logic              busy;
  logic              done;

  output_scan_reader_if #(.DATA_W(DATA_W)) out_if ();

  output_scan_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .start_addr   (start_addr),
    .word_count   (word_count),
    .read_address (read_address),
    .ram_q        (ram_q),
    .busy         (busy),
    .done         (done),
    .out_if       (out_if)
  );

  always #5 clk = ~clk;

  // Frame RAM: registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) ram_q <= mem[read_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sink: always ready, or a random ~50% pattern.
  bit rand_ready = 1'b0;
  initial out_if.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    out_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard / monitor, sampled on the falling edge.
  bit                mon_en = 1'b0;
  logic [DATA_W-1:0] exp_q [$];
  int                xfer_n, done_n, first_valid_cyc, last_xfer_cyc, done_cyc;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk) begin
    if (mon_en) begin
      check("fifo_count_le2", 32'(dut.count_q > 2'd2), 32'd0);
      if (prev_stall) begin
        check("hold_valid", 32'(out_if.out_valid), 32'd1);
        check("hold_data", out_if.out_data, prev_data);
      end
      if (out_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_if.out_valid && out_if.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(exp_q.size()), 32'd1);
        else                   check("data", out_if.out_data, exp_q.pop_front());
        xfer_n++;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
        check("busy_low_at_done", 32'(busy), 32'd0);
      end
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_data  = out_if.out_data;
    end
  end

  task automatic run_scan(input int sa, input int wc, input bit rnd, input bit poke_mid);
    int s_cyc;
    int budget;
    exp_q.delete();
    for (int i = 0; i < wc; i++) exp_q.push_back(mem[(sa + i) % DEPTH]);
    xfer_n = 0; done_n = 0; first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0;
    rand_ready = rnd;
    mon_en     = 1'b1;

    @(posedge clk); #1;
    start = 1'b1; start_addr = ADDR_W'(sa); word_count = (ADDR_W+1)'(wc);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = ADDR_W'($urandom);           // parameters must be latched
    word_count = (ADDR_W+1)'($urandom);

    if (poke_mid) begin
      repeat (4) @(posedge clk);
      #1;
      check("busy_mid_scan", 32'(busy), 32'd1);
      start = 1'b1; start_addr = ADDR_W'(sa + 40); word_count = (ADDR_W+1)'(3);
      @(posedge clk); #1;
      start = 1'b0;
    end

    budget = 40 * wc + 60;
    while (done_n == 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check("done_seen", 32'(done_n != 0), 32'd1);

    @(negedge clk); #1;
    check("done_single_pulse", 32'(done_n), 32'd1);
    check("done_low_after", 32'(done), 32'd0);
    check("busy_low_after", 32'(busy), 32'd0);
    check("xfer_count", 32'(xfer_n), 32'(wc));
    check("words_left", 32'(exp_q.size()), 32'd0);
    if (wc == 0) begin
      check("zero_done_latency", 32'(done_cyc - s_cyc), 32'd1);
      check("zero_never_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
    end else begin
      check("done_after_last", 32'(done_cyc - last_xfer_cyc), 32'd1);
      if (!rnd) begin
        check("first_valid_latency", 32'(first_valid_cyc - s_cyc), 32'd3);
        check("no_bubbles", 32'(last_xfer_cyc - first_valid_cyc), 32'(wc - 1));
      end
    end
    mon_en     = 1'b0;
    rand_ready = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; start_addr = '0; word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + 32'(i);

    repeat (3) @(posedge clk);
    #1;
    check("rst_read_address", 32'(read_address), 32'd0);
    check("rst_out_data", out_if.out_data, 32'd0);
    check("rst_out_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    n_rst = 1'b1;

    run_scan(0, 8, 1'b0, 1'b0);
    run_scan(125, 5, 1'b0, 1'b0);
    run_scan(3, 16, 1'b1, 1'b0);
    run_scan(60, 0, 1'b0, 1'b0);
    run_scan(0, 128, 1'b0, 1'b0);
    run_scan(30, 20, 1'b1, 1'b1);

    // Reset in the middle of a scan.
    @(posedge clk); #1;
    start = 1'b1; start_addr = ADDR_W'(10); word_count = (ADDR_W+1)'(40);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("midrst_read_address", 32'(read_address), 32'd0);
    check("midrst_out_data", out_if.out_data, 32'd0);
    check("midrst_out_valid", 32'(out_if.out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
      check("midrst_no_valid", 32'(out_if.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", 32'(done), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    run_scan(0, 8, 1'b0, 1'b0);

    // Random contents and random scans.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int k = 0; k < 8; k++)
      run_scan(int'($urandom_range(0, 127)), int'($urandom_range(0, 40)),
               1'($urandom_range(0, 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_scan_reader.md
Name: output_scan_reader

Overview:
- Downstream consumer of the output-controller frame RAM (32-bit data, 7-bit address, 1-cycle registered read).
- On a start pulse, sequentially reads a programmed run of words from the RAM and streams them out on a valid/ready interface toward the display/serializer stage.
- Hides the RAM read latency and absorbs downstream backpressure with a 2-entry skid buffer.
- Sustains one word per cycle when the sink is always ready.

Parameters:
- DATA_W, 32, RAM word and output data width
- ADDR_W, 7, RAM address width; the address space is 2^ADDR_W = 128 words

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse requesting a scan; ignored while busy
- start_addr  input  ADDR_W  first RAM address, latched on accepted start
- word_count  input  ADDR_W+1  number of words (0..128), latched on accepted start
- read_address  output  ADDR_W  registered address driven to RAM read port
- ram_q  input  DATA_W  RAM read data; holds mem[read_address of previous cycle]
- out_data  output  DATA_W  streamed word
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts word when out_valid & out_ready
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the final word is transferred

Behaviour:
- Reset (async, n_rst=0): read_address=0, out_data=0, out_valid=0, busy=0, done=0, FSM=IDLE, FIFO count=0, read-pending flag=0, internal counters=0.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 latches start_addr and word_count, sets busy=1 next cycle.
  - word_count=0 -> FIN directly, with no RAM reads.
  - Otherwise -> READ.
- READ: issues reads; after the last issue -> DRAIN.
- DRAIN: waits until FIFO empty and no read pending; the cycle the last word transfers -> FIN.
- FIN: done=1 for exactly one cycle, busy=0 in that same cycle, then -> IDLE.
  - For word_count=0: done pulses on the cycle after start.
- Read issue and capture:
  - A read of address A is issued in a cycle where read_address==A and the internal issue flag is 1.
  - The pending flag is set for the next cycle. In that cycle ram_q is captured into the FIFO tail at the closing edge.
- Address sequence: start_addr, start_addr+1, ..., modulo 2^ADDR_W (127 wraps to 0). read_address holds its last value when not issuing.
- Issue rule (credit): issue when count+pending <= 1, or when count+pending == 2 and a pop occurs this cycle. Never more than word_count issues per scan.
- FIFO (depth 2):
  - out_valid = (count>0); out_data = head entry.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by the credit rule; a bench assertion checks count<=2.
- Handshake:
  - Once out_valid=1, out_valid and out_data stay stable until out_ready=1.
  - out_ready has no combinational path to out_valid.
- Throughput and latency:
  - With out_ready held high, first out_valid=1 occurs 3 cycles after the start cycle.
  - Words then stream one per cycle, with no bubbles.
- Ordering: words are emitted strictly in address order; no drops, no duplicates.
- start while busy is ignored; the latched parameters are unchanged.
- Reset mid-scan:
  - Immediate return to reset values.
  - No done pulse; in-flight data is discarded.
- Words transferred in a scan = word_count exactly; word_count=128 covers the full RAM once.

Test Plan:
- Preload RAM mem[i]=0xA000_0000+i. Run start_addr=0, word_count=8, out_ready=1 -> out_data 0xA0000000..0xA0000007 on 8 consecutive cycles; first valid 3 cycles after start; done one cycle after last transfer.
- start_addr=125, word_count=5 -> addresses 125,126,127,0,1; data 0xA000007D,7E,7F,0xA0000000,0xA0000001.
- word_count=16, out_ready toggled with a random ~50% pattern -> all 16 words in order; out_data stable while valid & !ready; FIFO count never exceeds 2.
- word_count=0 -> no read issued, out_valid never 1, done pulses on the cycle after start, busy low after.
- start_addr=0, word_count=128, out_ready=1 -> 128 words in 128 consecutive cycles, matching mem[0..127].
- Second start pulsed while busy, mid-scan -> ignored with no change to the data sequence. Then n_rst asserted mid-scan -> all outputs 0 immediately, no done; a new scan after reset behaves like the first test.
